// File: rtl/rf_writeback_queue_if.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue_if : ALU/LSU writeback handshakes plus register file write port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rf_writeback_queue_if #(
   parameter int XLEN = 32
);
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;

   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;

   logic            we3;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3;

   // master: the execute/memory side that issues requests and observes the write port
   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      input  alu_ready, lsu_ready,
      input  we3, a3, wd3
   );

   // slave: the writeback queue itself
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      output alu_ready, lsu_ready,
      output we3, a3, wd3
   );
endinterface

`default_nettype wire

// File: rtl/rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue : round-robin ALU/LSU writeback FIFO driving the RF write port.
// Optional forwarding lookup enabled by macro WB_FWD_EN.   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  wire logic                        clk,
   input  wire logic                        rst_n,
   rf_writeback_queue_if.slave              bus,
   input  wire logic                        wb_stall,
   output logic [$clog2(DEPTH+1)-1:0]       count
`ifdef WB_FWD_EN
   ,
   input  wire logic [4:0]                  fwd_a,
   output logic                             fwd_hit,
   output logic [XLEN-1:0]                  fwd_data
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [4:0]      rd_mem   [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic            rr_lsu;

   logic            full;
   logic            empty;
   logic            grant_alu;
   logic            grant_lsu;
   logic            accept;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            push;
   logic            pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // rr_lsu=1 gives the LSU priority when both ports request together
   assign grant_lsu = bus.lsu_valid & (~bus.alu_valid | rr_lsu);
   assign grant_alu = bus.alu_valid & (~bus.lsu_valid | ~rr_lsu);

   // x0 writes are always accepted: they are dropped rather than stored
   assign bus.lsu_ready = grant_lsu & (~full | (bus.lsu_rd == 5'd0));
   assign bus.alu_ready = grant_alu & (~full | (bus.alu_rd == 5'd0));

   assign accept   = bus.lsu_ready | bus.alu_ready;
   assign sel_rd   = grant_lsu ? bus.lsu_rd   : bus.alu_rd;
   assign sel_data = grant_lsu ? bus.lsu_data : bus.alu_data;
   assign push     = accept & (sel_rd != 5'd0);
   assign pop      = ~empty & ~wb_stall;

   assign bus.we3 = pop;
   assign bus.a3  = empty ? 5'd0 : rd_mem[rd_ptr];
   assign bus.wd3 = empty ? '0   : data_mem[rd_ptr];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         rr_lsu  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         // point at the port that was not just served
         if (accept) begin
            rr_lsu <= grant_alu;
         end
      end
   end

   // Storage needs no reset: every read is qualified by the entry count.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= sel_rd;
         data_mem[wr_ptr] <= sel_data;
      end
   end

`ifdef WB_FWD_EN
   // Scan oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_q) && (fwd_a != 5'd0) &&
             (rd_mem[AW'(rd_ptr + AW'(i))] == fwd_a)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem[AW'(rd_ptr + AW'(i))];
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_queue : directed self-checking bench for rf_writeback_queue
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_writeback_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic       clk;
   logic       rst_n;
   logic       wb_stall;
   logic [2:0] count;
`ifdef WB_FWD_EN
   logic [4:0]      fwd_a;
   logic            fwd_hit;
   logic [XLEN-1:0] fwd_data;
`endif

   int n_checks;
   int n_errors;

   rf_writeback_queue_if #(.XLEN(XLEN)) bus ();

   rf_writeback_queue #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .wb_stall (wb_stall),
      .count    (count)
`ifdef WB_FWD_EN
      ,
      .fwd_a    (fwd_a),
      .fwd_hit  (fwd_hit),
      .fwd_data (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic alu_req(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.alu_valid = v;
      bus.alu_rd    = rd;
      bus.alu_data  = d;
   endtask

   task automatic lsu_req(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.lsu_valid = v;
      bus.lsu_rd    = rd;
      bus.lsu_data  = d;
   endtask

   task automatic idle();
      alu_req(1'b0, 5'd0, 32'h0);
      lsu_req(1'b0, 5'd0, 32'h0);
   endtask

   // inputs change just after a negedge; the posedge falls inside step
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      wb_stall = 1'b0;
      idle();
`ifdef WB_FWD_EN
      fwd_a = 5'd0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_count", 32'(count), 32'd0);
      check("reset_we3",   32'(bus.we3), 32'd0);
      check("reset_a3",    32'(bus.a3), 32'd0);
      check("reset_wd3",   bus.wd3, 32'd0);

      // 1: pending entries are discarded by reset
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_req(1'b1, 5'(8 + i), 32'h80 + 32'(i));
         #1;
         check("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
         step();
      end
      idle();
      #1;
      check("t1_count3", 32'(count), 32'd3);
      check("t1_we3_stalled", 32'(bus.we3), 32'd0);
      rst_n = 1'b0;
      step();
      check("t1_count_rst", 32'(count), 32'd0);
      check("t1_we3_rst", 32'(bus.we3), 32'd0);
      rst_n    = 1'b1;
      wb_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t1_no_write", 32'(bus.we3), 32'd0);
         step();
      end

      // 2: single ALU write, one-cycle latency
      alu_req(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      check("t2_alu_ready", 32'(bus.alu_ready), 32'd1);
      check("t2_we3_before", 32'(bus.we3), 32'd0);
      step();
      idle();
      #1;
      check("t2_we3", 32'(bus.we3), 32'd1);
      check("t2_a3", 32'(bus.a3), 32'd5);
      check("t2_wd3", bus.wd3, 32'hDEADBEEF);
      check("t2_count1", 32'(count), 32'd1);
      step();
      check("t2_count0", 32'(count), 32'd0);
      check("t2_we3_after", 32'(bus.we3), 32'd0);

      // 3: simultaneous requests after reset, LSU first
      do_reset();
      lsu_req(1'b1, 5'd1, 32'h11);
      alu_req(1'b1, 5'd2, 32'h22);
      #1;
      check("t3_lsu_ready", 32'(bus.lsu_ready), 32'd1);
      check("t3_alu_ready", 32'(bus.alu_ready), 32'd0);
      step();
      lsu_req(1'b0, 5'd0, 32'h0);
      #1;
      check("t3_alu_ready2", 32'(bus.alu_ready), 32'd1);
      check("t3_we3_a", 32'(bus.we3), 32'd1);
      check("t3_a3_a", 32'(bus.a3), 32'd1);
      check("t3_wd3_a", bus.wd3, 32'h11);
      step();
      idle();
      #1;
      check("t3_we3_b", 32'(bus.we3), 32'd1);
      check("t3_a3_b", 32'(bus.a3), 32'd2);
      check("t3_wd3_b", bus.wd3, 32'h22);
      step();
      check("t3_empty", 32'(bus.we3), 32'd0);

      // 4: fill under stall, full blocks, drain in order
      wb_stall = 1'b1;
      for (int i = 3; i <= 6; i++) begin
         alu_req(1'b1, 5'(i), 32'h30 + 32'(i));
         #1;
         check("t4_fill_ready", 32'(bus.alu_ready), 32'd1);
         step();
      end
      alu_req(1'b1, 5'd7, 32'h77);
      lsu_req(1'b1, 5'd12, 32'hC0);
      #1;
      check("t4_count_full", 32'(count), 32'd4);
      check("t4_alu_ready_full", 32'(bus.alu_ready), 32'd0);
      check("t4_lsu_ready_full", 32'(bus.lsu_ready), 32'd0);
      check("t4_we3_stalled", 32'(bus.we3), 32'd0);
      step();
      wb_stall = 1'b0;
      lsu_req(1'b0, 5'd0, 32'h0);
      #1;
      check("t4_no_passthru", 32'(bus.alu_ready), 32'd0);
      check("t4_we3_0", 32'(bus.we3), 32'd1);
      check("t4_a3_0", 32'(bus.a3), 32'd3);
      step();
      alu_req(1'b0, 5'd0, 32'h0);
      for (int i = 4; i <= 6; i++) begin
         #1;
         check("t4_we3_n", 32'(bus.we3), 32'd1);
         check("t4_a3_n", 32'(bus.a3), 32'(i));
         check("t4_wd3_n", bus.wd3, 32'h30 + 32'(i));
         check("t4_count_n", 32'(count), 32'(7 - i));
         step();
      end
      alu_req(1'b1, 5'd7, 32'h77);
      #1;
      check("t4_fifth_ready", 32'(bus.alu_ready), 32'd1);
      check("t4_drained", 32'(bus.we3), 32'd0);
      step();
      idle();
      #1;
      check("t4_fifth_a3", 32'(bus.a3), 32'd7);
      check("t4_fifth_wd3", bus.wd3, 32'h77);
      step();

      // 5: x0 writes complete the handshake but are dropped
      alu_req(1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      check("t5_alu_ready", 32'(bus.alu_ready), 32'd1);
      step();
      idle();
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t5_count", 32'(count), 32'd0);
         check("t5_we3", 32'(bus.we3), 32'd0);
         step();
      end
      wb_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_req(1'b1, 5'(20 + i), 32'(i));
         step();
      end
      alu_req(1'b1, 5'd0, 32'h5A);
      #1;
      check("t5_x0_ready_full", 32'(bus.alu_ready), 32'd1);
      step();
      idle();
      #1;
      check("t5_count_full", 32'(count), 32'd4);
      do_reset();

`ifdef WB_FWD_EN
      // 6: forwarding returns the youngest matching entry
      wb_stall = 1'b1;
      alu_req(1'b1, 5'd7, 32'hA);
      step();
      alu_req(1'b1, 5'd9, 32'hC);
      step();
      alu_req(1'b1, 5'd7, 32'hB);
      step();
      idle();
      fwd_a = 5'd7;
      #1;
      check("t6_hit7", 32'(fwd_hit), 32'd1);
      check("t6_data7", fwd_data, 32'hB);
      fwd_a = 5'd9;
      #1;
      check("t6_data9", fwd_data, 32'hC);
      fwd_a = 5'd0;
      #1;
      check("t6_hit0", 32'(fwd_hit), 32'd0);
      check("t6_data0", fwd_data, 32'h0);
      fwd_a = 5'd11;
      #1;
      check("t6_miss", 32'(fwd_hit), 32'd0);
      wb_stall = 1'b0;
      step();
      step();
      step();
      fwd_a = 5'd7;
      #1;
      check("t6_drained", 32'(fwd_hit), 32'd0);
      wb_stall = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
